pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 158 +++++++++++++++
 tb/tb_pc_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit -- program counter and fetch-request controller.
//
// Holds the architectural PC, presents it to instruction memory as a fetch
// request and selects the next PC from trap, branch, halt, stall and
// sequential-advance requests. A four-state FSM (RESET, FETCH, HALTED, ERROR)
// sequences the unit; a misaligned branch target parks it in ERROR until a
// trap or reset.
//
// Optional feature: define PC_UNIT_C_EXT_EN to add the isCompressed input.
// With it, the sequential increment becomes 2 for 16-bit instructions and
// branch targets need only be 2-byte aligned. Without it, the increment is
// always 4 and targets must be 4-byte aligned.
//
// Parameters
//   XLEN          datapath / PC width (32 or 64)
//   RESET_VECTOR  PC value loaded while reset is asserted
//   TRAP_VECTOR   PC value loaded on trap
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-high reset
//   stall         hold PC, no sequential advance
//   branchTaken   redirect to branchTarget
//   branchTarget  redirect address
//   trap          redirect to TRAP_VECTOR (from FETCH, HALTED or ERROR)
//   halt          enter HALTED from FETCH
//   resume        leave HALTED
//   fetchReady    instruction memory accepts the current PC
//   isCompressed  current instruction is 16-bit (PC_UNIT_C_EXT_EN only)
//   fetchValid    PC is a valid fetch request (FETCH state only)
//   PC            registered current PC
//   outPCAdder    PC + increment, wrapping modulo 2^XLEN
//   misaligned    sticky misaligned-target flag, cleared only by reset
//   state         FSM state encoding

module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            branchTaken,
  input  logic [XLEN-1:0] branchTarget,
  input  logic            trap,
  input  logic            halt,
  input  logic            resume,
  input  logic            fetchReady,
`ifdef PC_UNIT_C_EXT_EN
  input  logic            isCompressed,
`endif
  output logic            fetchValid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] outPCAdder,
  output logic            misaligned,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_FETCH  = 2'b01,
    ST_HALTED = 2'b10,
    ST_ERROR  = 2'b11
  } state_t;

  state_t cur_state;
  logic   compressed;
  logic   tgt_aligned;

`ifdef PC_UNIT_C_EXT_EN
  assign compressed = isCompressed;

  // Halfword-aligned instructions are legal once 16-bit encodings exist.
  function automatic logic target_aligned(input logic [1:0] low);
    return (low & 2'b01) == 2'b00;
  endfunction
`else
  assign compressed = 1'b0;

  function automatic logic target_aligned(input logic [1:0] low);
    return low == 2'b00;
  endfunction
`endif

  function automatic logic [XLEN-1:0] pc_increment(input logic is_16bit);
    return is_16bit ? XLEN'(2) : XLEN'(4);
  endfunction

  // Plain XLEN-bit addition: the carry out is dropped, giving the modulo wrap.
  assign outPCAdder  = PC + pc_increment(compressed);
  assign tgt_aligned = target_aligned(branchTarget[1:0]);
  assign state       = cur_state;

  // fetchValid is registered alongside the state so it is high exactly in
  // FETCH; every transition into FETCH sets it and every exit clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state  <= ST_RESET;
      PC         <= RESET_VECTOR;
      fetchValid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      case (cur_state)
        ST_RESET: begin
          cur_state  <= ST_FETCH;
          fetchValid <= 1'b1;
        end

        ST_FETCH: begin
          if (trap) begin
            PC <= TRAP_VECTOR;
          end else if (branchTaken) begin
            // A redirect abandons any un-accepted fetch; fetchReady is moot.
            if (tgt_aligned) begin
              PC <= branchTarget;
            end else begin
              cur_state  <= ST_ERROR;
              fetchValid <= 1'b0;
              misaligned <= 1'b1;
            end
          end else if (halt) begin
            cur_state  <= ST_HALTED;
            fetchValid <= 1'b0;
          end else if (fetchValid && fetchReady && !stall) begin
            PC <= outPCAdder;
          end
        end

        ST_HALTED: begin
          if (trap) begin
            cur_state  <= ST_FETCH;
            fetchValid <= 1'b1;
            PC         <= TRAP_VECTOR;
          end else if (resume) begin
            cur_state  <= ST_FETCH;
            fetchValid <= 1'b1;
          end
        end

        ST_ERROR: begin
          // misaligned deliberately survives the trap exit.
          if (trap) begin
            cur_state  <= ST_FETCH;
            fetchValid <= 1'b1;
            PC         <= TRAP_VECTOR;
          end
        end

        default: begin
          cur_state  <= ST_RESET;
          fetchValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam int XLEN = 32;

`ifdef PC_UNIT_C_EXT_EN
  localparam logic [XLEN-1:0] MIS_TGT = 32'h0000_0041;
`else
  localparam logic [XLEN-1:0] MIS_TGT = 32'h0000_0042;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            stall = 1'b0;
  logic            branchTaken = 1'b0;
  logic [XLEN-1:0] branchTarget = '0;
  logic            trap = 1'b0;
  logic            halt = 1'b0;
  logic            resume = 1'b0;
  logic            fetchReady = 1'b0;
  logic            isCompressed = 1'b0;
  logic            fetchValid;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] outPCAdder;
  logic            misaligned;
  logic [1:0]      state;

  int checks = 0;
  int failures = 0;

  pc_unit #(.XLEN(XLEN)) dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .trap        (trap),
    .halt        (halt),
    .resume      (resume),
    .fetchReady  (fetchReady),
`ifdef PC_UNIT_C_EXT_EN
    .isCompressed(isCompressed),
`endif
    .fetchValid  (fetchValid),
    .PC          (PC),
    .outPCAdder  (outPCAdder),
    .misaligned  (misaligned),
    .state       (state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [XLEN-1:0] pc,
                           input logic fv, input logic mis);
    check({tag, ".state"}, 64'(state), 64'(st));
    check({tag, ".pc"}, 64'(PC), 64'(pc));
    check({tag, ".fetchValid"}, 64'(fetchValid), 64'(fv));
    check({tag, ".misaligned"}, 64'(misaligned), 64'(mis));
  endtask

  initial begin
    // Asynchronous reset: visible before any clock edge (first edge at t=5).
    #2 reset = 1'b1;
    #1 check_all("async_reset", 2'b00, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    fetchReady = 1'b1;
    check_all("after_release", 2'b00, 32'h0, 1'b0, 1'b0);

    // Sequential advance.
    tick(); check_all("fetch0", 2'b01, 32'h0, 1'b1, 1'b0);
    tick(); check("seq4", 64'(PC), 64'h4);
    tick(); check("seq8", 64'(PC), 64'h8);
    check("adder12", 64'(outPCAdder), 64'hC);

    // fetchReady low holds the PC.
    fetchReady = 1'b0;
    tick(); check("nordy1", 64'(PC), 64'h8);
    tick(); check_all("nordy2", 2'b01, 32'h8, 1'b1, 1'b0);
    fetchReady = 1'b1;
    tick(); check("accept12", 64'(PC), 64'hC);

    // stall holds PC even with fetchReady.
    stall = 1'b1;
    tick(); check("stall", 64'(PC), 64'hC);
    stall = 1'b0;

    // trap beats branch in the same cycle, then branch alone.
    fetchReady = 1'b0;
    trap = 1'b1; branchTaken = 1'b1; branchTarget = 32'h40;
    tick(); check_all("trap_over_br", 2'b01, 32'h100, 1'b1, 1'b0);
    trap = 1'b0;
    tick(); check("branch40", 64'(PC), 64'h40);
    branchTaken = 1'b0; fetchReady = 1'b1;
    tick(); check("seq44", 64'(PC), 64'h44);

    // Halt at 0x20 with fetchReady high.
    fetchReady = 1'b0; branchTaken = 1'b1; branchTarget = 32'h20;
    tick(); check("br20", 64'(PC), 64'h20);
    branchTaken = 1'b0; halt = 1'b1; fetchReady = 1'b1;
    tick(); check_all("halted", 2'b10, 32'h20, 1'b0, 1'b0);
    halt = 1'b0; branchTaken = 1'b1; branchTarget = 32'h80; stall = 1'b1;
    tick(); check_all("halt_ign_br", 2'b10, 32'h20, 1'b0, 1'b0);
    branchTaken = 1'b0; stall = 1'b0; resume = 1'b1; fetchReady = 1'b0;
    tick(); check_all("resumed", 2'b01, 32'h20, 1'b1, 1'b0);
    resume = 1'b0;

    // Misaligned target -> ERROR; other inputs ignored; trap exits.
    branchTaken = 1'b1; branchTarget = MIS_TGT;
    tick(); check_all("misalign", 2'b11, 32'h20, 1'b0, 1'b1);
    branchTarget = 32'h40; fetchReady = 1'b1; resume = 1'b1; halt = 1'b1;
    tick(); check_all("err_hold", 2'b11, 32'h20, 1'b0, 1'b1);
    branchTaken = 1'b0; resume = 1'b0; halt = 1'b0; fetchReady = 1'b0; trap = 1'b1;
    tick(); check_all("err_trap", 2'b01, 32'h100, 1'b1, 1'b1);
    trap = 1'b0;

    // Adder wrap.
    branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFC;
    tick(); check("br_top", 64'(PC), 64'hFFFF_FFFC);
    check("adder_wrap", 64'(outPCAdder), 64'h0);
    branchTaken = 1'b0; fetchReady = 1'b1;
    tick(); check("pc_wrap", 64'(PC), 64'h0);

`ifdef PC_UNIT_C_EXT_EN
    fetchReady = 1'b0; branchTaken = 1'b1; branchTarget = 32'h10;
    tick(); check("br10", 64'(PC), 64'h10);
    branchTaken = 1'b0; isCompressed = 1'b1; fetchReady = 1'b1;
    tick(); check("c_seq12", 64'(PC), 64'h12);
    isCompressed = 1'b0;
`endif

    // Reset mid-redirect: pending branch discarded, sticky flag cleared.
    fetchReady = 1'b0; branchTaken = 1'b1; branchTarget = 32'h40;
    #3 reset = 1'b1;
    #1 check_all("mid_reset", 2'b00, 32'h0, 1'b0, 1'b0);
    branchTaken = 1'b0;
    tick();
    reset = 1'b0;
    tick(); check_all("post_reset", 2'b01, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
